reg_scoreboard: RTL and testbench

Producer-side companion to the EX-stage forwarding logic in the P5 five-stage MIPS pipeline. Forwarding consumes results once they reach MEM or WB; this block tracks register writes from the moment they issue out of ID until they retire in WB. It raises a decode stall whenever a source register's value cannot yet be forwarded: a load or multi-cycle result still in flight, or a saturated pending count. It sits beside the ID/EX pipeline register and is driven by the ID, MEM and WB stages.

---
 rtl/reg_scoreboard_pkg.sv | 23 ++
 rtl/reg_scoreboard_if.sv | 35 +++
 rtl/sb_counter.sv | 44 ++++
 rtl/reg_scoreboard.sv | 85 ++++++++
 tb/tb_reg_scoreboard.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_scoreboard_pkg.sv
// Shared pipeline definitions for the register write scoreboard.
// Register index width, zero register and default pending-counter width.
package pipe_defs;

    localparam int unsigned NREG  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 2;

    typedef logic [REG_W-1:0] reg_idx_t;

    localparam reg_idx_t ZERO_REG = '0;

    // Register 0 is never tracked, so its decode is always suppressed.
    function automatic logic [NREG-1:0] reg_onehot(input logic valid, input reg_idx_t rd);
        logic [NREG-1:0] oh;
        oh = '0;
        if (valid && (rd != ZERO_REG)) begin
            oh[rd] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// ID/MEM/WB event ports into the register scoreboard and its stall/busy outputs.
interface reg_scoreboard_if;
    import pipe_defs::*;

    logic             id_valid;
    reg_idx_t         id_rs;
    reg_idx_t         id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             id_we;
    reg_idx_t         id_rd;
    logic             id_late;
    logic             avail_valid;
    reg_idx_t         avail_rd;
    logic             wb_valid;
    reg_idx_t         wb_rd;
    logic             kill_valid;
    reg_idx_t         kill_rd;
    logic             kill_late;
    logic             stall;
    logic [NREG-1:0]  busy_mask;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_we, id_rd, id_late,
        output avail_valid, avail_rd, wb_valid, wb_rd, kill_valid, kill_rd, kill_late,
        input  stall, busy_mask
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_we, id_rd, id_late,
        input  avail_valid, avail_rd, wb_valid, wb_rd, kill_valid, kill_rd, kill_late,
        output stall, busy_mask
    );

endinterface

// File: rtl/sb_counter.sv
// Saturating up/down counter with one increment and two decrement strobes.
// Nets all strobes in one edge; holds at zero and flags an underflow attempt.
module sb_counter #(
    parameter int unsigned CntW = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            inc_i,
    input  logic            dec_a_i,
    input  logic            dec_b_i,
    output logic [CntW-1:0] count_o,
    output logic            underflow_o
);

    localparam logic [CntW-1:0] CntMax = '1;

    logic [CntW-1:0] count_q, count_d;
    int              sum;

    always_comb begin
        count_d     = count_q;
        underflow_o = 1'b0;
        sum         = int'(count_q) + int'(inc_i) - int'(dec_a_i) - int'(dec_b_i);
        if (sum < 0) begin
            count_d     = '0;
            underflow_o = 1'b1;
        end else if (sum > int'(CntMax)) begin
            count_d = CntMax;
        end else begin
            count_d = CntW'(sum);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/reg_scoreboard.sv
// Tracks in-flight register writers from ID issue to WB retire and raises a
// decode stall when a source is still late or a destination counter is full.
module reg_scoreboard #(
    parameter int unsigned CntW = pipe_defs::CNT_W
) (
    input  logic            clk,
    input  logic            reset_n,
    reg_scoreboard_if.slave bus
);
    import pipe_defs::*;

    localparam logic [CntW-1:0] CntMax = '1;

    logic [CntW-1:0] cnt  [NREG];
    logic [CntW-1:0] late [NREG];

    logic [NREG-1:0] issue_oh, late_oh, avail_oh, wb_oh, kill_oh, kill_late_oh;
    logic [NREG-1:0] cnt_uf, late_uf, busy;
    logic            stall_rs, stall_rt, stall_rd, stall, issue;
    logic            err_underflow;

    always_comb begin
        stall_rs = bus.id_use_rs && (bus.id_rs != ZERO_REG) && (late[bus.id_rs] != '0);
        stall_rt = bus.id_use_rt && (bus.id_rt != ZERO_REG) && (late[bus.id_rt] != '0);
        stall_rd = bus.id_we && (bus.id_rd != ZERO_REG) && (cnt[bus.id_rd] == CntMax);
        stall    = reset_n && bus.id_valid && (stall_rs || stall_rt || stall_rd);
        // A stalled instruction never issues, so it cannot block on its own rd.
        issue    = bus.id_valid && bus.id_we && (bus.id_rd != ZERO_REG) && !stall;

        issue_oh     = reg_onehot(issue, bus.id_rd);
        late_oh      = reg_onehot(issue && bus.id_late, bus.id_rd);
        avail_oh     = reg_onehot(bus.avail_valid, bus.avail_rd);
        wb_oh        = reg_onehot(bus.wb_valid, bus.wb_rd);
        kill_oh      = reg_onehot(bus.kill_valid, bus.kill_rd);
        kill_late_oh = reg_onehot(bus.kill_valid && bus.kill_late, bus.kill_rd);
    end

    for (genvar r = 0; r < NREG; r++) begin : g_reg
        if (r == 0) begin : g_zero
            assign cnt[r]     = '0;
            assign late[r]    = '0;
            assign cnt_uf[r]  = 1'b0;
            assign late_uf[r] = 1'b0;
            assign busy[r]    = 1'b0;
        end else begin : g_track
            sb_counter #(
                .CntW (CntW)
            ) u_cnt (
                .clk         (clk),
                .reset_n     (reset_n),
                .inc_i       (issue_oh[r]),
                .dec_a_i     (wb_oh[r]),
                .dec_b_i     (kill_oh[r]),
                .count_o     (cnt[r]),
                .underflow_o (cnt_uf[r])
            );

            sb_counter #(
                .CntW (CntW)
            ) u_late (
                .clk         (clk),
                .reset_n     (reset_n),
                .inc_i       (late_oh[r]),
                .dec_a_i     (avail_oh[r]),
                .dec_b_i     (kill_late_oh[r]),
                .count_o     (late[r]),
                .underflow_o (late_uf[r])
            );

            assign busy[r] = |cnt[r];

            a_late_le_cnt: assert property (@(posedge clk) disable iff (!reset_n)
                late[r] <= cnt[r]);
        end
    end

    // Release without a matching writer is a protocol error; counters hold at zero.
    assign err_underflow = (|cnt_uf) | (|late_uf);

    c_err_underflow: cover property (@(posedge clk) disable iff (!reset_n) err_underflow);

    assign bus.stall     = stall;
    assign bus.busy_mask = busy;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: a reference model pushes expected
// stall/underflow/busy values to a queue, popped as the DUT produces them.
module tb_reg_scoreboard;
    import pipe_defs::*;

    localparam int CntMaxM = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    reg_scoreboard_if bus ();

    reg_scoreboard dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        string       tag;
        logic [63:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   cnt_m  [NREG];
    int   late_m [NREG];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb_q.push_back(e);
    endtask

    task automatic pop_check(input logic [63:0] act);
        exp_t e;
        if (sb_q.size() == 0) begin
            check("sb_underrun", 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            check(e.tag, act, e.exp);
        end
    endtask

    function automatic logic model_stall();
        logic s;
        s = 1'b0;
        if (bus.id_valid) begin
            if (bus.id_use_rs && bus.id_rs != 0 && late_m[bus.id_rs] != 0) s = 1'b1;
            if (bus.id_use_rt && bus.id_rt != 0 && late_m[bus.id_rt] != 0) s = 1'b1;
            if (bus.id_we && bus.id_rd != 0 && cnt_m[bus.id_rd] == CntMaxM) s = 1'b1;
        end
        return s && reset_n;
    endfunction

    function automatic logic [NREG-1:0] model_busy();
        logic [NREG-1:0] b;
        for (int r = 0; r < NREG; r++) b[r] = (cnt_m[r] != 0);
        return b;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) begin
            cnt_m[r]  = 0;
            late_m[r] = 0;
        end
    endtask

    task automatic clr();
        bus.id_valid    = 1'b0;
        bus.id_rs       = '0;
        bus.id_rt       = '0;
        bus.id_use_rs   = 1'b0;
        bus.id_use_rt   = 1'b0;
        bus.id_we       = 1'b0;
        bus.id_rd       = '0;
        bus.id_late     = 1'b0;
        bus.avail_valid = 1'b0;
        bus.avail_rd    = '0;
        bus.wb_valid    = 1'b0;
        bus.wb_rd       = '0;
        bus.kill_valid  = 1'b0;
        bus.kill_rd     = '0;
        bus.kill_late   = 1'b0;
    endtask

    task automatic issue(input int rd, input logic is_late);
        bus.id_valid = 1'b1;
        bus.id_we    = 1'b1;
        bus.id_rd    = reg_idx_t'(rd);
        bus.id_late  = is_late;
    endtask

    task automatic exp_stall(input string tag, input logic v);
        #1;
        check(tag, bus.stall, v);
    endtask

    // Called at a negedge with inputs applied; returns at the next negedge.
    task automatic cycle(input string tag);
        logic st, uf, iss;
        int   nc [NREG];
        int   nl [NREG];
        st = model_stall();
        push_exp({tag, ".stall"}, st);
        iss = bus.id_valid && bus.id_we && bus.id_rd != 0 && !st;
        uf  = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            nc[r] = cnt_m[r];
            nl[r] = late_m[r];
            if (r != 0) begin
                nc[r] = cnt_m[r] + int'(iss && bus.id_rd == r)
                      - int'(bus.wb_valid && bus.wb_rd == r)
                      - int'(bus.kill_valid && bus.kill_rd == r);
                nl[r] = late_m[r] + int'(iss && bus.id_late && bus.id_rd == r)
                      - int'(bus.avail_valid && bus.avail_rd == r)
                      - int'(bus.kill_valid && bus.kill_late && bus.kill_rd == r);
                if (nc[r] < 0) begin nc[r] = 0; uf = 1'b1; end
                if (nl[r] < 0) begin nl[r] = 0; uf = 1'b1; end
                if (nc[r] > CntMaxM) nc[r] = CntMaxM;
                if (nl[r] > CntMaxM) nl[r] = CntMaxM;
            end
        end
        push_exp({tag, ".uf"}, uf);
        #2;
        pop_check(bus.stall);
        pop_check(dut.err_underflow);
        @(posedge clk);
        for (int r = 0; r < NREG; r++) begin
            cnt_m[r]  = nc[r];
            late_m[r] = nl[r];
        end
        push_exp({tag, ".busy"}, model_busy());
        #1;
        pop_check(bus.busy_mask);
        @(negedge clk);
    endtask

    initial begin
        clr();
        model_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst.busy", bus.busy_mask, 0);
        check("rst.stall", bus.stall, 0);
        reset_n = 1'b1;

        // Build cnt[5]=2 and a late writer of 7, then reset under a live stall.
        issue(5, 1'b0); cycle("pre.i5a");
        cycle("pre.i5b");
        clr(); issue(7, 1'b1); cycle("pre.i7");
        clr(); bus.id_valid = 1'b1; bus.id_use_rs = 1'b1; bus.id_rs = 5'd7;
        exp_stall("pre.stall", 1'b1);
        #1;
        reset_n = 1'b0;
        #1;
        check("rst.mid.stall", bus.stall, 0);
        check("rst.mid.busy", bus.busy_mask, 0);
        check("rst.mid.cnt5", dut.cnt[5], 0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        clr();

        // Register 0 is never tracked.
        issue(0, 1'b1); cycle("zero");
        check("zero.busy", bus.busy_mask, 0);

        // Load-use: one bubble, released by avail.
        clr(); issue(8, 1'b1); cycle("lu.load");
        clr(); issue(10, 1'b0); bus.id_use_rs = 1'b1; bus.id_rs = 5'd8;
        bus.avail_valid = 1'b1; bus.avail_rd = 5'd8;
        exp_stall("lu.stall1", 1'b1);
        cycle("lu.use0");
        bus.avail_valid = 1'b0;
        exp_stall("lu.stall0", 1'b0);
        cycle("lu.use1");
        clr(); bus.wb_valid = 1'b1; bus.wb_rd = 5'd8; cycle("lu.wb8");
        check("lu.busy8", bus.busy_mask[8], 0);
        bus.wb_rd = 5'd10; cycle("lu.wb10");

        // ALU back-to-back: forwardable, no stall.
        clr(); issue(9, 1'b0); cycle("alu.iss");
        clr(); bus.id_valid = 1'b1; bus.id_use_rs = 1'b1; bus.id_rs = 5'd9;
        exp_stall("alu.nostall", 1'b0);
        cycle("alu.use");
        check("alu.busy9", bus.busy_mask[9], 1);
        clr(); bus.wb_valid = 1'b1; bus.wb_rd = 5'd9; cycle("alu.wb");
        check("alu.busy9_clr", bus.busy_mask[9], 0);

        // Saturation of rd=3.
        clr(); issue(3, 1'b0);
        cycle("sat.i1"); cycle("sat.i2"); cycle("sat.i3");
        exp_stall("sat.full", 1'b1);
        cycle("sat.h1"); cycle("sat.h2");
        bus.wb_valid = 1'b1; bus.wb_rd = 5'd3;
        exp_stall("sat.wbedge", 1'b1);
        cycle("sat.wb");
        bus.wb_valid = 1'b0;
        exp_stall("sat.free", 1'b0);
        cycle("sat.i4");
        clr(); bus.wb_valid = 1'b1; bus.wb_rd = 5'd3;
        cycle("sat.d1"); cycle("sat.d2"); cycle("sat.d3");

        // Simultaneous events on rd=4.
        clr(); issue(4, 1'b0); cycle("sim.i1");
        bus.wb_valid = 1'b1; bus.wb_rd = 5'd4; cycle("sim.iwb");
        check("sim.cnt4", dut.cnt[4], 1);
        clr(); issue(4, 1'b1); cycle("sim.ilate");
        clr(); bus.id_valid = 1'b1; bus.id_use_rt = 1'b1; bus.id_rt = 5'd4;
        exp_stall("sim.use", 1'b1);
        cycle("sim.use");
        bus.kill_valid = 1'b1; bus.kill_rd = 5'd4; bus.kill_late = 1'b1;
        exp_stall("sim.killedge", 1'b1);
        cycle("sim.kill");
        check("sim.late4", dut.late[4], 0);
        bus.kill_valid = 1'b0; bus.kill_late = 1'b0;
        exp_stall("sim.release", 1'b0);
        cycle("sim.go");
        clr(); bus.wb_valid = 1'b1; bus.wb_rd = 5'd4; cycle("sim.wb");
        check("sim.busy4", bus.busy_mask[4], 0);

        // Underflow: release with nothing pending.
        clr(); bus.wb_valid = 1'b1; bus.wb_rd = 5'd6;
        #1;
        check("uf.flag", dut.err_underflow, 1);
        cycle("uf.wb6");
        check("uf.cnt6", dut.cnt[6], 0);
        clr(); cycle("idle");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
